event_ddr_wr_arb: RTL and testbench

EVENT_DDR_WR_ARB -- requirements
Module: event_ddr_wr_arb

---
 rtl/event_ddr_wr_arb.sv | 241 ++++++++++++++++++++++++
 tb/tb_event_ddr_wr_arb.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/event_ddr_wr_arb.sv
// Round-robin arbiter funnelling NREQ write requesters onto one AXI4 write master port.
// One burst in flight at a time; per-requester outstanding-burst counters throttle grants.
module event_ddr_wr_arb #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned MAX_OUT = 15
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  init_calib_complete,
  // requester AW
  input  logic [NREQ-1:0]       s_aw_valid,
  output logic [NREQ-1:0]       s_aw_ready,
  input  logic [32*NREQ-1:0]    s_aw_addr,
  input  logic [8*NREQ-1:0]     s_aw_len,
  // requester W
  input  logic [512*NREQ-1:0]   s_w_data,
  input  logic [64*NREQ-1:0]    s_w_strb,
  input  logic [NREQ-1:0]       s_w_last,
  input  logic [NREQ-1:0]       s_w_valid,
  output logic [NREQ-1:0]       s_w_ready,
  // requester B
  output logic [NREQ-1:0]       s_b_valid,
  input  logic [NREQ-1:0]       s_b_ready,
  output logic [1:0]            s_b_resp,
  // master AXI4 write
  output logic [31:0]           m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic [2:0]            m_axi_awid,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [511:0]          m_axi_wdata,
  output logic [63:0]           m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [2:0]            m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic                  err_wlast
);

  localparam int unsigned GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] gnt_q, gnt_d;
  logic [GW-1:0] last_gnt_q, last_gnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    beat_q, beat_d;
  logic          err_q, err_d;
  logic [3:0]    outstanding_q [NREQ];
  logic [3:0]    outstanding_d [NREQ];

  logic [NREQ-1:0] eligible;
  logic            found;
  logic [GW-1:0]   pick;
  logic [GW-1:0]   cand;
  logic [31:0]     pick_addr;
  logic [7:0]      pick_len;
  logic            sel_wvalid;
  logic            sel_wlast;
  logic [511:0]    sel_wdata;
  logic [63:0]     sel_wstrb;
  logic            len_last;
  logic            aw_hs;
  logic            w_hs;
  logic            b_hs;
  logic [NREQ-1:0] ost_inc;
  logic [NREQ-1:0] ost_dec;

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      eligible[i] = s_aw_valid[i] && (outstanding_q[i] < 4'(MAX_OUT)) && init_calib_complete;
    end
  end

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    found = 1'b0;
    pick  = last_gnt_q;
    cand  = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = GW'((32'(last_gnt_q) + k) % NREQ);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    pick_addr = '0;
    pick_len  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (GW'(i) == pick) begin
        pick_addr = s_aw_addr[32*i +: 32];
        pick_len  = s_aw_len[8*i +: 8];
      end
    end
  end

  always_comb begin
    sel_wvalid = 1'b0;
    sel_wlast  = 1'b0;
    sel_wdata  = '0;
    sel_wstrb  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (GW'(i) == gnt_q) begin
        sel_wvalid = s_w_valid[i];
        sel_wlast  = s_w_last[i];
        sel_wdata  = s_w_data[512*i +: 512];
        sel_wstrb  = s_w_strb[64*i +: 64];
      end
    end
  end

  assign len_last = (beat_q == len_q);

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    last_gnt_d    = last_gnt_q;
    addr_d        = addr_q;
    len_d         = len_q;
    beat_d        = beat_q;
    err_d         = err_q;
    s_aw_ready    = '0;
    s_w_ready     = '0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_wlast   = 1'b0;
    aw_hs         = 1'b0;
    w_hs          = 1'b0;
    case (state_q)
      StIdle: begin
        if (found) begin
          s_aw_ready[pick] = 1'b1;
          gnt_d            = pick;
          last_gnt_d       = pick;
          addr_d           = pick_addr;
          len_d            = pick_len;
          state_d          = StAddr;
        end
      end
      StAddr: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) begin
          aw_hs   = 1'b1;
          beat_d  = '0;
          state_d = StData;
        end
      end
      StData: begin
        m_axi_wvalid     = sel_wvalid;
        m_axi_wlast      = len_last;
        s_w_ready[gnt_q] = m_axi_wready;
        if (sel_wvalid && m_axi_wready) begin
          w_hs   = 1'b1;
          beat_d = beat_q + 8'd1;
          // Beat count comes from the captured len; requester's last is only audited.
          if (sel_wlast != len_last) begin
            err_d = 1'b1;
          end
          if (len_last) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Unknown bids are accepted and dropped so the controller never stalls on them.
  always_comb begin
    s_b_valid    = '0;
    m_axi_bready = 1'b1;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (m_axi_bid == 3'(i)) begin
        s_b_valid[i] = m_axi_bvalid;
        m_axi_bready = s_b_ready[i];
      end
    end
  end

  assign s_b_resp = m_axi_bresp;
  assign b_hs     = m_axi_bvalid && m_axi_bready;

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      ost_inc[i]       = aw_hs && (gnt_q == GW'(i));
      ost_dec[i]       = b_hs && (m_axi_bid == 3'(i));
      outstanding_d[i] = outstanding_q[i];
      if (ost_inc[i] && !ost_dec[i] && (outstanding_q[i] != 4'hF)) begin
        outstanding_d[i] = outstanding_q[i] + 4'd1;
      end else if (ost_dec[i] && !ost_inc[i] && (outstanding_q[i] != 4'h0)) begin
        outstanding_d[i] = outstanding_q[i] - 4'd1;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= StIdle;
      gnt_q      <= '0;
      last_gnt_q <= GW'(NREQ - 1);
      addr_q     <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      err_q      <= 1'b0;
      for (int unsigned i = 0; i < NREQ; i++) begin
        outstanding_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      err_q      <= err_d;
      for (int unsigned i = 0; i < NREQ; i++) begin
        outstanding_q[i] <= outstanding_d[i];
      end
    end
  end

  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = len_q;
  assign m_axi_awsize  = 3'b110;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awid    = 3'(gnt_q);
  assign m_axi_wdata   = sel_wdata;
  assign m_axi_wstrb   = sel_wstrb;
  assign err_wlast     = err_q;

endmodule

// File: tb/tb_event_ddr_wr_arb.sv
// Bench for event_ddr_wr_arb: directed requests, expected AW/W traffic queued at issue time
// and checked by an independent monitor on the master port.
module tb_event_ddr_wr_arb;

  logic           aclk = 1'b0;
  logic           aresetn = 1'b1;
  logic           init_calib_complete = 1'b0;
  logic [3:0]     s_aw_valid = '0;
  logic [3:0]     s_aw_ready;
  logic [127:0]   s_aw_addr = '0;
  logic [31:0]    s_aw_len = '0;
  logic [2047:0]  s_w_data;
  logic [255:0]   s_w_strb;
  logic [3:0]     s_w_last;
  logic [3:0]     s_w_valid = 4'hF;
  logic [3:0]     s_w_ready;
  logic [3:0]     s_b_valid;
  logic [3:0]     s_b_ready = 4'hF;
  logic [1:0]     s_b_resp;
  logic [31:0]    m_axi_awaddr;
  logic [7:0]     m_axi_awlen;
  logic [2:0]     m_axi_awsize;
  logic [1:0]     m_axi_awburst;
  logic [2:0]     m_axi_awid;
  logic           m_axi_awvalid;
  logic           m_axi_awready = 1'b1;
  logic [511:0]   m_axi_wdata;
  logic [63:0]    m_axi_wstrb;
  logic           m_axi_wlast;
  logic           m_axi_wvalid;
  logic           m_axi_wready = 1'b1;
  logic [2:0]     m_axi_bid = '0;
  logic [1:0]     m_axi_bresp = '0;
  logic           m_axi_bvalid = 1'b0;
  logic           m_axi_bready;
  logic           err_wlast;

  event_ddr_wr_arb #(.NREQ(4), .MAX_OUT(15)) dut (
    .aclk(aclk), .aresetn(aresetn), .init_calib_complete(init_calib_complete),
    .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_addr(s_aw_addr), .s_aw_len(s_aw_len),
    .s_w_data(s_w_data), .s_w_strb(s_w_strb), .s_w_last(s_w_last), .s_w_valid(s_w_valid),
    .s_w_ready(s_w_ready), .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_b_resp(s_b_resp),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awid(m_axi_awid), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .err_wlast(err_wlast)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  id;
  } aw_t;

  typedef struct packed {
    logic [511:0] data;
    logic [63:0]  strb;
    logic         last;
  } w_t;

  aw_t awq[$];
  w_t  wq[$];
  aw_t ae;
  w_t  we;
  int  n_checks = 0;
  int  n_fail = 0;
  int  wbeat[4];
  logic [3:0] early_last = '0;

  function automatic logic [511:0] wpat(int r, int b);
    logic [511:0] v;
    v = '0;
    v[31:0] = {8'hC0 | 8'(r), 8'(b), 16'hBEEF};
    v[511:480] = ~v[31:0];
    return v;
  endfunction

  function automatic logic [63:0] spat(int r, int b);
    return {8'(r), 48'h0000_FFFF_0000, 8'(b)};
  endfunction

  // Requester data model: each requester walks its own beat index on every accepted beat.
  always_comb begin
    s_w_data = '0;
    s_w_strb = '0;
    s_w_last = '0;
    for (int i = 0; i < 4; i++) begin
      s_w_data[512*i +: 512] = wpat(i, wbeat[i]);
      s_w_strb[64*i +: 64]   = spat(i, wbeat[i]);
      s_w_last[i] = early_last[i] ? (wbeat[i] == 0) : (wbeat[i] == int'(s_aw_len[8*i +: 8]));
    end
  end

  initial begin
    logic [3:0] hs;
    for (int i = 0; i < 4; i++) wbeat[i] = 0;
    forever begin
      @(negedge aclk);
      hs = s_w_valid & s_w_ready;
      @(posedge aclk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (!aresetn) wbeat[i] = 0;
        else if (hs[i]) wbeat[i] = (wbeat[i] == int'(s_aw_len[8*i +: 8])) ? 0 : wbeat[i] + 1;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the queued expectation for every master-side handshake.
  always @(negedge aclk) begin
    if (aresetn === 1'b1 && m_axi_awvalid === 1'b1 && m_axi_awready) begin
      if (awq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL aw_unexpected: got id %0d addr 0x%0h, expected none", m_axi_awid,
                 m_axi_awaddr);
      end else begin
        ae = awq.pop_front();
        check("aw_addr", 64'(m_axi_awaddr), 64'(ae.addr));
        check("aw_len", 64'(m_axi_awlen), 64'(ae.len));
        check("aw_id", 64'(m_axi_awid), 64'(ae.id));
        check("aw_size", 64'(m_axi_awsize), 64'(3'b110));
        check("aw_burst", 64'(m_axi_awburst), 64'(2'b01));
      end
    end
    if (aresetn === 1'b1 && m_axi_wvalid === 1'b1 && m_axi_wready) begin
      if (wq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL w_unexpected: got data 0x%0h, expected none", m_axi_wdata[31:0]);
      end else begin
        we = wq.pop_front();
        n_checks++;
        if (m_axi_wdata !== we.data || m_axi_wstrb !== we.strb) begin
          n_fail++;
          $display("FAIL w_data: got %h/%h expected %h/%h", m_axi_wdata, m_axi_wstrb,
                   we.data, we.strb);
        end
        check("w_last", 64'(m_axi_wlast), 64'(we.last));
      end
    end
  end

  task automatic expect_burst(input int r, input logic [31:0] a, input int len);
    awq.push_back('{addr: a, len: 8'(len), id: 3'(r)});
    for (int b = 0; b <= len; b++) wq.push_back('{data: wpat(r, b), strb: spat(r, b), last: (b == len)});
  endtask

  task automatic set_req(input int r, input logic [31:0] a, input int len);
    s_aw_addr[32*r +: 32] = a;
    s_aw_len[8*r +: 8]    = 8'(len);
  endtask

  task automatic wait_grant(output int idx);
    idx = -1;
    for (int c = 0; c < 60; c++) begin
      @(negedge aclk);
      if (s_aw_ready != 4'b0) begin
        for (int i = 0; i < 4; i++) if (s_aw_ready[i]) idx = i;
        check("aw_ready_onehot", 64'($onehot(s_aw_ready)), 64'd1);
        break;
      end
    end
    if (idx < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL grant_timeout: got no s_aw_ready, expected a grant");
    end
  endtask

  task automatic single(input int r, input logic [31:0] a, input int len);
    int g;
    set_req(r, a, len);
    expect_burst(r, a, len);
    s_aw_valid[r] = 1'b1;
    wait_grant(g);
    check("grant_id", 64'(g), 64'(r));
    @(posedge aclk);
    #1;
    s_aw_valid[r] = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge aclk);
      if (awq.size() == 0 && wq.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d AW / %0d W pending, expected 0", awq.size(), wq.size());
      awq.delete();
      wq.delete();
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic no_grant(input int n, input string name);
    logic [3:0] acc;
    logic       acc_aw;
    acc = '0;
    acc_aw = 1'b0;
    repeat (n) begin
      @(negedge aclk);
      acc = acc | s_aw_ready;
      acc_aw = acc_aw | m_axi_awvalid;
    end
    check(name, 64'({acc, acc_aw}), 64'd0);
    @(posedge aclk);
    #1;
  endtask

  task automatic send_b(input int id, input logic [1:0] resp);
    logic [3:0] exp_v;
    logic       exp_r;
    logic [1:0] ix;
    ix = id[1:0];
    exp_v = (id < 4) ? (4'b0001 << ix) : 4'b0000;
    exp_r = (id < 4) ? s_b_ready[ix] : 1'b1;
    m_axi_bvalid = 1'b1;
    m_axi_bid = 3'(id);
    m_axi_bresp = resp;
    @(negedge aclk);
    check("b_valid", 64'(s_b_valid), 64'(exp_v));
    check("b_ready", 64'(m_axi_bready), 64'(exp_r));
    check("b_resp", 64'(s_b_resp), 64'(resp));
    @(posedge aclk);
    #1;
    m_axi_bvalid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge aclk);
    #2;
    aresetn = 1'b0;
    #1;
    check("rst_awvalid", 64'(m_axi_awvalid), 64'd0);
    check("rst_wvalid", 64'(m_axi_wvalid), 64'd0);
    check("rst_aw_ready", 64'(s_aw_ready), 64'd0);
    check("rst_w_ready", 64'(s_w_ready), 64'd0);
    check("rst_err_wlast", 64'(err_wlast), 64'd0);
    check("rst_awaddr", 64'(m_axi_awaddr), 64'd0);
    check("rst_awlen", 64'(m_axi_awlen), 64'd0);
    awq.delete();
    wq.delete();
    s_aw_valid = '0;
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int g;
    realtime t_prev, t_now;
    bit seen;

    // Single 4-beat burst from requester 0, with AW held off for a few cycles.
    do_reset();
    init_calib_complete = 1'b1;
    m_axi_awready = 1'b0;
    single(0, 32'h0000_1000, 3);
    repeat (3) begin
      @(negedge aclk);
      check("awvalid_hold", 64'(m_axi_awvalid), 64'd1);
    end
    @(posedge aclk);
    #1;
    m_axi_awready = 1'b1;
    drain();
    send_b(0, 2'b00);

    // All four requesting continuously: 0,1,2,3,0 with three cycles per burst.
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 32'h2000 + 32'(i) * 32'h100, 0);
    for (int k = 0; k < 5; k++) expect_burst(k % 4, 32'h2000 + 32'(k % 4) * 32'h100, 0);
    s_aw_valid = 4'hF;
    t_prev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_grant(g);
      check("rr_order", 64'(g), 64'(k % 4));
      t_now = $realtime;
      if (k > 0) check("rr_spacing", 64'(int'((t_now - t_prev) / 10.0)), 64'd3);
      t_prev = t_now;
    end
    @(posedge aclk);
    #1;
    s_aw_valid = '0;
    drain();

    // Requester 1 saturates its outstanding count, is skipped, then freed by one B.
    do_reset();
    set_req(1, 32'h3000, 0);
    set_req(2, 32'h4000, 0);
    for (int k = 0; k < 15; k++) expect_burst(1, 32'h3000, 0);
    s_aw_valid[1] = 1'b1;
    for (int k = 0; k < 15; k++) begin
      wait_grant(g);
      check("sat_grant", 64'(g), 64'd1);
    end
    @(posedge aclk);
    #1;
    expect_burst(2, 32'h4000, 0);
    s_aw_valid[2] = 1'b1;
    wait_grant(g);
    check("skip_full_req", 64'(g), 64'd2);
    @(posedge aclk);
    #1;
    s_aw_valid[2] = 1'b0;
    drain();
    no_grant(8, "req1_blocked");
    expect_burst(1, 32'h3000, 0);
    send_b(1, 2'b00);
    wait_grant(g);
    check("req1_freed", 64'(g), 64'd1);
    @(posedge aclk);
    #1;
    s_aw_valid[1] = 1'b0;
    drain();
    send_b(5, 2'b10);
    s_b_ready = 4'b0111;
    send_b(3, 2'b01);
    s_b_ready = 4'hF;

    // Calibration gating, including a drop while a burst is in DATA.
    do_reset();
    init_calib_complete = 1'b0;
    set_req(0, 32'h5000, 3);
    s_aw_valid[0] = 1'b1;
    no_grant(6, "calib_block");
    expect_burst(0, 32'h5000, 3);
    init_calib_complete = 1'b1;
    wait_grant(g);
    check("calib_grant", 64'(g), 64'd0);
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge aclk);
      if (m_axi_wvalid) begin
        seen = 1'b1;
        break;
      end
    end
    check("calib_reach_data", 64'(seen), 64'd1);
    @(posedge aclk);
    #1;
    init_calib_complete = 1'b0;
    drain();
    no_grant(6, "calib_stall_after");
    s_aw_valid[0] = 1'b0;
    init_calib_complete = 1'b1;

    // Early s_w_last sets err_wlast; simultaneous AW and B keep the count unchanged.
    do_reset();
    check("err_clear", 64'(err_wlast), 64'd0);
    early_last[2] = 1'b1;
    single(2, 32'h6000, 1);
    drain();
    early_last[2] = 1'b0;
    check("err_set", 64'(err_wlast), 64'd1);
    for (int k = 0; k < 13; k++) begin
      single(2, 32'h6100 + 32'(k) * 32'h40, 0);
      drain();
    end
    m_axi_awready = 1'b0;
    single(2, 32'h6800, 0);
    @(negedge aclk);
    check("aw_wait_b", 64'(m_axi_awvalid), 64'd1);
    @(posedge aclk);
    #1;
    m_axi_awready = 1'b1;
    send_b(2, 2'b00);
    drain();
    single(2, 32'h6900, 0);
    drain();
    s_aw_valid[2] = 1'b1;
    no_grant(8, "req2_full");
    s_aw_valid[2] = 1'b0;
    check("err_sticky", 64'(err_wlast), 64'd1);

    // Reset during the second beat of an 8-beat burst.
    do_reset();
    single(0, 32'h7000, 7);
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge aclk);
      if (m_axi_wvalid && m_axi_wready) begin
        seen = 1'b1;
        break;
      end
    end
    check("first_beat_seen", 64'(seen), 64'd1);
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 32'h8000 + 32'(i) * 32'h100, 0);
    expect_burst(0, 32'h8000, 0);
    s_aw_valid = 4'b1011;
    wait_grant(g);
    check("post_reset_first", 64'(g), 64'd0);
    @(posedge aclk);
    #1;
    s_aw_valid = '0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
